// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// alu_exec_stage : execute-stage ALU, single-cycle ops plus 16-step shift-add MUL
// rev 1.0
// ============================================================================
module alu_exec_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] opa;   // doubles as the multiplicand during MUL
  logic [WIDTH-1:0] opb;   // doubles as the multiplier during MUL
  logic [WIDTH-1:0] acc;
  logic [3:0]       cnt;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    sum     = opa + opb;
    diff    = opa - opb;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OP_SRA:  alu_res = $signed(opa) >>> opb[3:0];
      default: alu_res = '0;
    endcase
  end

  assign acc_next = opb[0] ? (acc + opa) : acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= op;
            opa  <= data_a;
            opb  <= data_b;
            busy <= 1'b1;
            if (op == OP_MUL) begin
              acc   <= '0;
              cnt   <= '0;
              state <= ST_MUL;
            end else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          result   <= alu_res;
          zero     <= (alu_res == '0);
          overflow <= alu_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        ST_MUL: begin
          acc <= acc_next;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            result   <= acc_next;
            zero     <= (acc_next == '0);
            overflow <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_exec_stage : directed vectors checked every cycle against a behavioural model
// rev 1.0
// ============================================================================
module tb_alu_exec_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic [15:0] result;
  logic        zero;
  logic        overflow;
  logic        busy;
  logic        done;

  alu_exec_stage #(.WIDTH(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .data_a   (data_a),
    .data_b   (data_b),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // model state: what the outputs must be after the most recent edge
  logic [15:0] m_result;
  logic        m_zero;
  logic        m_ovf;
  logic        m_busy;
  logic        m_done;
  logic [15:0] m_pend;
  logic        m_pend_ovf;
  int          m_left;

  function automatic logic [16:0] golden(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    int          sa;
    int          sb;
    int          r;
    int unsigned p;
    logic [15:0] res;
    logic        v;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    v   = 1'b0;
    res = 16'h0000;
    case (o)
      3'd0: begin r = sa + sb; v = (r > 32767) || (r < -32768); res = r[15:0]; end
      3'd1: begin r = sa - sb; v = (r > 32767) || (r < -32768); res = r[15:0]; end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = (sa < sb) ? 16'h0001 : 16'h0000;
      3'd6: begin p = a * b; res = p[15:0]; end
      default: begin r = sa >>> b[3:0]; res = r[15:0]; end
    endcase
    return {v, res};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_result = 16'h0000; m_zero = 1'b0; m_ovf = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    m_pend = 16'h0000; m_pend_ovf = 1'b0;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (reset) begin
      model_reset();
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_result = m_pend;
        m_zero   = (m_pend == 16'h0000);
        m_ovf    = m_pend_ovf;
        m_done   = 1'b1;
        m_busy   = 1'b0;
      end
    end else if (start) begin
      {m_pend_ovf, m_pend} = golden(op, data_a, data_b);
      m_left = (op == 3'b110) ? 16 : 1;
      m_busy = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("result",   {16'h0, result}, {16'h0, m_result});
    check("zero",     {31'h0, zero},     {31'h0, m_zero});
    check("overflow", {31'h0, overflow}, {31'h0, m_ovf});
    check("busy",     {31'h0, busy},     {31'h0, m_busy});
    check("done",     {31'h0, done},     {31'h0, m_done});
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1 compare_all();
    @(negedge clock);
  endtask

  // issue one op and run until the model says it completed; lat = edges from acceptance to done
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, output int lat);
    start = 1'b1; op = o; data_a = a; data_b = b;
    cycle();
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      lat++;
      if (m_done) break;
    end
    check("complete", {31'h0, done}, 32'h1);
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        v;
  } vec_t;

  vec_t vecs[8];
  int   lat;

  initial begin
    vecs[0] = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1};
    vecs[1] = '{3'd0, 16'hFFE0, 16'h0004, 16'hFFE4, 1'b0};
    vecs[2] = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0};
    vecs[3] = '{3'd5, 16'hFFFF, 16'h0001, 16'h0001, 1'b0};
    vecs[4] = '{3'd7, 16'h8000, 16'h0004, 16'hF800, 1'b0};
    vecs[5] = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1};
    vecs[6] = '{3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0};
    vecs[7] = '{3'd4, 16'hAAAA, 16'h0FF0, 16'hA55A, 1'b0};

    reset = 1'b1; start = 1'b0; op = 3'd0; data_a = 16'h0; data_b = 16'h0;
    model_reset();
    #1 compare_all();
    @(negedge clock);
    cycle();
    reset = 1'b0;
    cycle();

    // single-cycle ops with hand-computed results
    foreach (vecs[i]) begin
      run_op(vecs[i].o, vecs[i].a, vecs[i].b, lat);
      check("vec_result",   {16'h0, result},   {16'h0, vecs[i].r});
      check("vec_overflow", {31'h0, overflow}, {31'h0, vecs[i].v});
      check("vec_zero",     {31'h0, zero},     {31'h0, (vecs[i].r == 16'h0)});
      check("single_latency", lat, 1);
    end

    run_op(3'd6, 16'h0123, 16'h0045, lat);
    check("mul_result", {16'h0, result}, 32'h4E6F);
    check("mul_latency", lat, 16);

    // MUL with a stray start mid-operation that must be ignored
    start = 1'b1; op = 3'd6; data_a = 16'hFFFF; data_b = 16'hFFFF;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        start = 1'b1; op = 3'd0; data_a = 16'h1111; data_b = 16'h2222;
      end else begin
        start = 1'b0;
      end
      cycle();
    end
    check("mul_ffff_result", {16'h0, result}, 32'h0001);
    check("mul_ffff_done",   {31'h0, done},   32'h1);
    cycle();

    // reset during MUL iteration 8
    start = 1'b1; op = 3'd6; data_a = 16'h0123; data_b = 16'h0045;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_result", {16'h0, result}, 32'h0);
    check("rst_busy",   {31'h0, busy},   32'h0);
    @(negedge clock);
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    run_op(3'd0, 16'h0002, 16'h0003, lat);
    check("post_rst_add", {16'h0, result}, 32'h0005);

    // back-to-back: second op accepted in the done cycle of the first
    start = 1'b1; op = 3'd0; data_a = 16'h0001; data_b = 16'h0001;
    cycle();
    cycle();
    check("b2b_first_done", {31'h0, done}, 32'h1);
    op = 3'd3; data_a = 16'h00F0; data_b = 16'h000F;
    cycle();
    start = 1'b0;
    check("b2b_second_busy", {31'h0, busy}, 32'h1);
    cycle();
    check("b2b_or_result", {16'h0, result}, 32'h00FF);
    check("b2b_or_done",   {31'h0, done},   32'h1);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
